wb_port_arbiter: RTL and testbench

- Shares the single regfile write port between the in-order pipeline writeback stage and one auxiliary multi-cycle producer, such as a future divider or an uncached load unit.
- The pipeline always has priority. Auxiliary results wait in a small in-order FIFO.
- A starvation counter requests a pipeline bubble so that auxiliary results can drain.
- The block also flags RAW hazards against queued auxiliary results for the hazard unit.

---
 rtl/wb_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: the pipeline writeback has priority, auxiliary results
// queue in an in-order FIFO, with a starvation bubble request and RAW hazard flagging.
module wb_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RADDR_WIDTH  = 5,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pipe_we,
  input  logic [RADDR_WIDTH-1:0] pipe_waddr,
  input  logic [DATA_WIDTH-1:0]  pipe_wdata,
  input  logic                   aux_valid,
  output logic                   aux_ready,
  input  logic [RADDR_WIDTH-1:0] aux_waddr,
  input  logic [DATA_WIDTH-1:0]  aux_wdata,
  input  logic [RADDR_WIDTH-1:0] rs1,
  input  logic [RADDR_WIDTH-1:0] rs2,
  output logic                   raw_hazard,
  output logic                   stall_req,
  output logic                   rf_we,
  output logic [RADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic [RADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]         cnt_q, cnt_d;
  logic [3:0]             starve_q, starve_d;

  logic                   rf_we_q, rf_we_d;
  logic [RADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;

  logic full, empty, pipe_win, push, pop, raw;

  always_comb begin
    full     = (cnt_q == FULL_CNT);
    empty    = (cnt_q == '0);
    pipe_win = pipe_we && (pipe_waddr != '0);
    // x0 results complete the handshake but never occupy a slot
    push     = aux_valid && !full && (aux_waddr != '0);
    pop      = !pipe_win && !empty;
  end

  always_comb begin
    vld_d  = vld_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + PTR_W'(1);
    end
    if (push) begin
      vld_d[wptr_q] = 1'b1;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_win) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = addr_q[rptr_q];
      rf_wdata_d = data_q[rptr_q];
    end
  end

  always_comb begin
    raw = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_q[i] && (((rs1 != '0) && (addr_q[i] == rs1)) ||
                       ((rs2 != '0) && (addr_q[i] == rs2)))) begin
        raw = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr_q] <= aux_waddr;
      data_q[wptr_q] <= aux_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      vld_q      <= vld_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign aux_ready  = !full;
  assign stall_req  = (starve_q >= LIMIT_C) && !empty;
  assign raw_hazard = raw;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a queue-based reference model and scoreboard.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_waddr;
  logic [31:0] aux_wdata;
  logic [4:0]  rs1, rs2;
  logic        raw_hazard, stall_req, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(
    .DATA_WIDTH(32),
    .RADDR_WIDTH(5),
    .FIFO_DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
    .rs1(rs1), .rs2(rs2),
    .raw_hazard(raw_hazard), .stall_req(stall_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  rf_t  sb[$];
  rf_t  m_rf = '0;
  int   m_starve = 0;

  // Reference model: evaluated on each rising edge from the inputs held stable across it.
  always @(posedge clk) begin
    ent_t h;
    int   sz;
    logic pw;
    if (!rst_n) begin
      mq.delete();
      m_starve = 0;
      m_rf     = '0;
    end else begin
      sz = mq.size();
      pw = pipe_we && (pipe_waddr != 5'd0);
      if (pw) begin
        m_rf = '{1'b1, pipe_waddr, pipe_wdata};
      end else if (sz > 0) begin
        h    = mq.pop_front();
        m_rf = '{1'b1, h.a, h.d};
      end else begin
        m_rf.we = 1'b0;
      end
      if (sz == 0 || !pw) m_starve = 0;
      else if (m_starve < 15) m_starve = m_starve + 1;
      if (aux_valid && sz < DEPTH && aux_waddr != 5'd0) mq.push_back('{aux_waddr, aux_wdata});
    end
    sb.push_back(m_rf);
  end

  function automatic logic model_raw();
    logic r = 1'b0;
    foreach (mq[i]) begin
      if ((rs1 != 5'd0 && mq[i].a == rs1) || (rs2 != 5'd0 && mq[i].a == rs2)) r = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    rf_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s/scoreboard: observed empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "/rf_we"},    64'(rf_we),    64'(e.we));
      chk({tag, "/rf_waddr"}, 64'(rf_waddr), 64'(e.addr));
      chk({tag, "/rf_wdata"}, 64'(rf_wdata), 64'(e.data));
    end
    chk({tag, "/aux_ready"},  64'(aux_ready),  64'(mq.size() < DEPTH));
    chk({tag, "/stall_req"},  64'(stall_req),  64'(m_starve >= LIMIT && mq.size() > 0));
    chk({tag, "/raw_hazard"}, 64'(raw_hazard), 64'(model_raw()));
  endtask

  initial begin
    rst_n = 1'b0; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    aux_valid = 1'b0; aux_waddr = '0; aux_wdata = '0; rs1 = '0; rs2 = '0;

    // Reset held for two edges with a pending aux result
    aux_valid = 1'b1; aux_waddr = 5'd9; aux_wdata = 32'h99; rs1 = 5'd9;
    tick("rst0");
    tick("rst1");
    chk("rst/rf_we", 64'(rf_we), 64'd0);
    chk("rst/rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst/rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rst/aux_ready", 64'(aux_ready), 64'd1);
    chk("rst/stall_req", 64'(stall_req), 64'd0);
    chk("rst/raw_hazard", 64'(raw_hazard), 64'd0);
    rst_n = 1'b1; aux_valid = 1'b0; rs1 = '0;
    tick("idle");

    // Pipeline only
    pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF;
    tick("pipe");
    chk("pipe/rf_we", 64'(rf_we), 64'd1);
    chk("pipe/rf_waddr", 64'(rf_waddr), 64'd5);
    chk("pipe/rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    pipe_waddr = 5'd0; pipe_wdata = 32'h1111;
    tick("pipe_x0");
    chk("pipe_x0/rf_we", 64'(rf_we), 64'd0);
    chk("pipe_x0/hold", 64'(rf_wdata), 64'hDEADBEEF);

    // Aux path, two-edge latency
    pipe_we = 1'b0; aux_valid = 1'b1; aux_waddr = 5'd7; aux_wdata = 32'h12345678; rs1 = 5'd7;
    tick("aux_push");
    chk("aux_push/rf_we", 64'(rf_we), 64'd0);
    chk("aux_push/raw", 64'(raw_hazard), 64'd1);
    aux_valid = 1'b0;
    tick("aux_pop");
    chk("aux_pop/rf_we", 64'(rf_we), 64'd1);
    chk("aux_pop/rf_waddr", 64'(rf_waddr), 64'd7);
    chk("aux_pop/rf_wdata", 64'(rf_wdata), 64'h12345678);
    chk("aux_pop/raw", 64'(raw_hazard), 64'd0);
    rs1 = '0;

    // Collision and backpressure
    rs1 = 5'd21; rs2 = 5'd22;
    pipe_we = 1'b1; aux_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pipe_waddr = 5'(10 + i); pipe_wdata = 32'(100 + i);
      if (i < 3) begin aux_waddr = 5'(20 + i); aux_wdata = 32'(200 + i); end
      tick("coll");
      if (i == 1) chk("coll/full", 64'(aux_ready), 64'd0);
    end
    pipe_we = 1'b0;
    tick("drain0");
    chk("drain0/rf_waddr", 64'(rf_waddr), 64'd20);
    chk("drain0/ready", 64'(aux_ready), 64'd1);
    tick("drain1");
    chk("drain1/rf_waddr", 64'(rf_waddr), 64'd21);
    aux_valid = 1'b0;
    tick("drain2");
    chk("drain2/rf_wdata", 64'(rf_wdata), 64'd202);
    tick("drain3");
    rs1 = '0; rs2 = '0;

    // Starvation
    pipe_we = 1'b1; pipe_waddr = 5'd14; pipe_wdata = 32'h14;
    aux_valid = 1'b1; aux_waddr = 5'd12; aux_wdata = 32'hAA;
    tick("starve_push");
    aux_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("starve");
      chk("starve/stall_req", 64'(stall_req), 64'(i == 3));
    end
    pipe_we = 1'b0;
    tick("starve_release");
    chk("starve_release/rf_waddr", 64'(rf_waddr), 64'd12);
    chk("starve_release/rf_wdata", 64'(rf_wdata), 64'hAA);
    chk("starve_release/stall", 64'(stall_req), 64'd0);

    // Contract violation: count saturates, pipeline keeps winning
    pipe_we = 1'b1; aux_valid = 1'b1; aux_waddr = 5'd13; aux_wdata = 32'hBB;
    tick("sat_push");
    aux_valid = 1'b0;
    for (int i = 0; i < 18; i++) tick("sat");
    chk("sat/stall_req", 64'(stall_req), 64'd1);
    pipe_we = 1'b0;
    tick("sat_release");
    chk("sat_release/rf_waddr", 64'(rf_waddr), 64'd13);

    // Ordering with duplicate destinations
    rs2 = 5'd3;
    aux_valid = 1'b1; aux_waddr = 5'd3; aux_wdata = 32'd1;
    tick("ord0");
    chk("ord0/raw", 64'(raw_hazard), 64'd1);
    aux_wdata = 32'd2;
    tick("ord1");
    chk("ord1/rf_wdata", 64'(rf_wdata), 64'd1);
    aux_valid = 1'b0;
    tick("ord2");
    chk("ord2/rf_we", 64'(rf_we), 64'd1);
    chk("ord2/rf_wdata", 64'(rf_wdata), 64'd2);
    rs2 = '0;

    // Aux write to x0: accepted, never written
    aux_valid = 1'b1; aux_waddr = 5'd0; aux_wdata = 32'hCC;
    tick("aux_x0");
    aux_valid = 1'b0;
    tick("aux_x0_after");
    chk("aux_x0/rf_we", 64'(rf_we), 64'd0);

    // Reset mid-operation discards the queue
    pipe_we = 1'b1; pipe_waddr = 5'd8; aux_valid = 1'b1; aux_waddr = 5'd9; aux_wdata = 32'hEE;
    tick("mid_push");
    aux_valid = 1'b0; rst_n = 1'b0;
    tick("mid_rst");
    rst_n = 1'b1; pipe_we = 1'b0;
    tick("mid_after");
    chk("mid_after/rf_we", 64'(rf_we), 64'd0);
    chk("mid_after/ready", 64'(aux_ready), 64'd1);
    tick("mid_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
